// File: rtl/ysyx_25040111_lsu.sv
// Memory-access / writeback stage: takes one abt_* request at a time, runs at most one
// AXI-lite-style bus transaction, then retires it through the GPR/CSR write ports in WB.
module ysyx_25040111_lsu (
    input  logic        clock,
    input  logic        reset,
    input  logic        abt_valid,
    output logic        abt_ready,
    input  logic        abt_men,
    input  logic        abt_write,
    input  logic [31:0] abt_addr,
    input  logic [31:0] abt_wdata,
    input  logic [1:0]  abt_mask,
    input  logic        abt_rsign,
    input  logic [4:0]  abt_ard,
    input  logic [31:0] abt_rd,
    input  logic        abt_gen,
    input  logic [11:0] abt_acsr,
    input  logic [31:0] abt_csr,
    input  logic        abt_sen,
    input  logic [31:0] abt_pc,
    output logic        abt_finish,
    output logic [4:0]  abt_frd,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_awvalid,
    input  logic        mem_awready,
    output logic [31:0] mem_awaddr,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_bvalid,
    output logic        mem_bready,
    input  logic [1:0]  mem_bresp,
    output logic        err_o,
    output logic [3:0]  errtp_o,
    output logic [31:0] err_pc
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, WB} state_t;

    state_t      state;
    logic [1:0]  r_off;
    logic [1:0]  r_mask;
    logic        r_rsign;
    logic [4:0]  r_ard;
    logic [31:0] r_rd;
    logic        r_gen;
    logic [11:0] r_acsr;
    logic [31:0] r_csr;
    logic        r_sen;
    logic [31:0] r_pc;
    logic        aw_done;
    logic        w_done;

    logic        accept;
    logic        misal;
    logic        aw_fire;
    logic        w_fire;
    logic [3:0]  strb_base;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic        wb_go;
    logic        wb_fault;
    logic [3:0]  wb_tp;
    logic        wb_gen;
    logic [4:0]  wb_ard;
    logic [31:0] wb_data;
    logic        wb_sen;
    logic [11:0] wb_acsr;
    logic [31:0] wb_csr;
    logic [31:0] wb_pc;

    assign abt_ready = (state == IDLE) && !reset;
    assign accept    = abt_valid && abt_ready;
    assign aw_fire   = mem_awvalid && mem_awready;
    assign w_fire    = mem_wvalid && mem_wready;

    always_comb begin
        misal = ((abt_mask == 2'b10) && abt_addr[0]) ||
                ((abt_mask == 2'b11) && (abt_addr[1:0] != 2'b00));
        case (abt_mask)
            2'b10:   strb_base = 4'b0011;
            2'b11:   strb_base = 4'b1111;
            default: strb_base = 4'b0001;
        endcase
        lane = mem_rdata >> {r_off, 3'b000};
        case (r_mask)
            2'b10:   load_val = {{16{r_rsign & lane[15]}}, lane[15:0]};
            2'b11:   load_val = lane;
            default: load_val = {{24{r_rsign & lane[7]}}, lane[7:0]};
        endcase
    end

    // WB contents are sourced from the live request when retiring straight out of IDLE
    // (non-memory or misaligned), otherwise from the captured request.
    always_comb begin
        wb_go    = 1'b0;
        wb_fault = 1'b0;
        wb_tp    = '0;
        wb_gen   = r_gen;
        wb_ard   = r_ard;
        wb_data  = r_rd;
        wb_sen   = r_sen;
        wb_acsr  = r_acsr;
        wb_csr   = r_csr;
        wb_pc    = r_pc;
        case (state)
            IDLE: if (accept && (!abt_men || misal)) begin
                wb_go    = 1'b1;
                wb_fault = abt_men;
                wb_tp    = abt_write ? 4'd6 : 4'd4;
                wb_gen   = abt_gen;
                wb_ard   = abt_ard;
                wb_data  = abt_rd;
                wb_sen   = abt_sen;
                wb_acsr  = abt_acsr;
                wb_csr   = abt_csr;
                wb_pc    = abt_pc;
            end
            RDATA: if (mem_rvalid) begin
                wb_go    = 1'b1;
                wb_fault = (mem_rresp != 2'b00);
                wb_tp    = 4'd5;
                wb_data  = load_val;
            end
            WRESP: if (mem_bvalid) begin
                wb_go    = 1'b1;
                wb_fault = (mem_bresp != 2'b00);
                wb_tp    = 4'd7;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            r_off       <= '0;
            r_mask      <= '0;
            r_rsign     <= 1'b0;
            r_ard       <= '0;
            r_rd        <= '0;
            r_gen       <= 1'b0;
            r_acsr      <= '0;
            r_csr       <= '0;
            r_sen       <= 1'b0;
            r_pc        <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            abt_finish  <= 1'b0;
            abt_frd     <= '0;
            gpr_wen     <= 1'b0;
            gpr_waddr   <= '0;
            gpr_wdata   <= '0;
            csr_wen     <= 1'b0;
            csr_waddr   <= '0;
            csr_wdata   <= '0;
            mem_arvalid <= 1'b0;
            mem_araddr  <= '0;
            mem_rready  <= 1'b0;
            mem_awvalid <= 1'b0;
            mem_awaddr  <= '0;
            mem_wvalid  <= 1'b0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            mem_bready  <= 1'b0;
            err_o       <= 1'b0;
            errtp_o     <= '0;
            err_pc      <= '0;
        end else begin
            gpr_wen    <= 1'b0;
            csr_wen    <= 1'b0;
            abt_finish <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    r_off   <= abt_addr[1:0];
                    r_mask  <= abt_mask;
                    r_rsign <= abt_rsign;
                    r_ard   <= abt_ard;
                    r_rd    <= abt_rd;
                    r_gen   <= abt_gen;
                    r_acsr  <= abt_acsr;
                    r_csr   <= abt_csr;
                    r_sen   <= abt_sen;
                    r_pc    <= abt_pc;
                    if (abt_men && !misal) begin
                        if (abt_write) begin
                            state       <= WREQ;
                            mem_awvalid <= 1'b1;
                            mem_wvalid  <= 1'b1;
                            mem_awaddr  <= {abt_addr[31:2], 2'b00};
                            mem_wdata   <= abt_wdata << {abt_addr[1:0], 3'b000};
                            mem_wstrb   <= strb_base << abt_addr[1:0];
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                        end else begin
                            state       <= RADDR;
                            mem_arvalid <= 1'b1;
                            mem_araddr  <= {abt_addr[31:2], 2'b00};
                        end
                    end
                end
                RADDR: if (mem_arready) begin
                    mem_arvalid <= 1'b0;
                    mem_rready  <= 1'b1;
                    state       <= RDATA;
                end
                RDATA: if (mem_rvalid) mem_rready <= 1'b0;
                WREQ: begin
                    if (aw_fire) begin
                        mem_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_fire) begin
                        mem_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        mem_bready <= 1'b1;
                        state      <= WRESP;
                    end
                end
                WRESP: if (mem_bvalid) mem_bready <= 1'b0;
                WB: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (wb_go) begin
                state      <= WB;
                gpr_wen    <= wb_gen && (wb_ard != 5'd0) && !wb_fault;
                gpr_waddr  <= wb_ard;
                gpr_wdata  <= wb_data;
                csr_wen    <= wb_sen;
                csr_waddr  <= wb_acsr;
                csr_wdata  <= wb_csr;
                abt_finish <= 1'b1;
                abt_frd    <= wb_ard;
                err_o      <= wb_fault;
                if (wb_fault) begin
                    errtp_o <= wb_tp;
                    err_pc  <= wb_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Scoreboard bench for the LSU: expected WB records are queued at accept and popped at
// abt_finish; a configurable-latency bus responder serves the AXI-lite-style channels.
module tb_ysyx_25040111_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        abt_valid = 1'b0, abt_ready;
    logic        abt_men = 1'b0, abt_write = 1'b0;
    logic [31:0] abt_addr = '0, abt_wdata = '0;
    logic [1:0]  abt_mask = '0;
    logic        abt_rsign = 1'b0;
    logic [4:0]  abt_ard = '0;
    logic [31:0] abt_rd = '0;
    logic        abt_gen = 1'b0;
    logic [11:0] abt_acsr = '0;
    logic [31:0] abt_csr = '0;
    logic        abt_sen = 1'b0;
    logic [31:0] abt_pc = '0;
    logic        abt_finish;
    logic [4:0]  abt_frd;
    logic        gpr_wen, csr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata, csr_wdata;
    logic [11:0] csr_waddr;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [31:0] mem_araddr, mem_rdata;
    logic [1:0]  mem_rresp, mem_bresp;
    logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
    logic [31:0] mem_awaddr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        err_o;
    logic [3:0]  errtp_o;
    logic [31:0] err_pc;

    always #5 clock = ~clock;

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .abt_valid(abt_valid), .abt_ready(abt_ready), .abt_men(abt_men), .abt_write(abt_write),
        .abt_addr(abt_addr), .abt_wdata(abt_wdata), .abt_mask(abt_mask), .abt_rsign(abt_rsign),
        .abt_ard(abt_ard), .abt_rd(abt_rd), .abt_gen(abt_gen),
        .abt_acsr(abt_acsr), .abt_csr(abt_csr), .abt_sen(abt_sen), .abt_pc(abt_pc),
        .abt_finish(abt_finish), .abt_frd(abt_frd),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
        .err_o(err_o), .errtp_o(errtp_o), .err_pc(err_pc)
    );

    typedef struct packed {
        logic        gw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cw;
        logic [11:0] ca;
        logic [31:0] cd;
        logic [4:0]  frd;
        logic        err;
        logic [3:0]  tp;
        logic [31:0] pc;
    } wb_t;

    typedef struct packed {
        logic        men, write;
        logic [31:0] addr, wdata;
        logic [1:0]  mask;
        logic        rsign;
        logic [4:0]  ard;
        logic [31:0] rd;
        logic        gen;
        logic [11:0] acsr;
        logic [31:0] csr;
        logic        sen;
        logic [31:0] pc;
    } req_t;

    wb_t exp_q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  acc_cnt = 0;

    // Bus responder configuration and statistics
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] mem_word = '0;
    logic [1:0]  rresp_cfg = '0, bresp_cfg = '0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, arv_cyc = 0, awv_cyc = 0, wv_cyc = 0, stray = 0;
    logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    always @(posedge clock) if (!reset && abt_valid && abt_ready) acc_cnt++;

    initial begin : responder
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit r_pend, aw_got, w_got, b_pend;
        mem_arready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rresp = '0;
        mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mem_arready = 0; mem_rvalid = 0; mem_awready = 0; mem_wready = 0; mem_bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
            end else begin
                if (mem_arvalid) arv_cyc++;
                if (mem_awvalid) awv_cyc++;
                if (mem_wvalid) wv_cyc++;
                if ((aw_got && mem_awvalid) || (w_got && mem_wvalid)) stray++;
                mem_rvalid = 0;
                if (r_pend) begin
                    if (r_cnt >= r_delay) begin
                        mem_rvalid = 1; mem_rdata = mem_word; mem_rresp = rresp_cfg;
                        if (mem_rready) r_pend = 0;
                    end else r_cnt++;
                end
                mem_bvalid = 0;
                if (b_pend) begin
                    if (b_cnt >= b_delay) begin
                        mem_bvalid = 1; mem_bresp = bresp_cfg;
                        if (mem_bready) begin b_pend = 0; aw_got = 0; w_got = 0; end
                    end else b_cnt++;
                end
                mem_arready = 0;
                if (mem_arvalid) begin
                    if (ar_cnt >= ar_delay) begin
                        mem_arready = 1; ar_hs++; last_araddr = mem_araddr;
                        ar_cnt = 0; r_pend = 1; r_cnt = 0;
                    end else ar_cnt++;
                end
                mem_awready = 0;
                if (mem_awvalid && !aw_got) begin
                    if (aw_cnt >= aw_delay) begin
                        mem_awready = 1; aw_hs++; last_awaddr = mem_awaddr; aw_got = 1; aw_cnt = 0;
                    end else aw_cnt++;
                end
                mem_wready = 0;
                if (mem_wvalid && !w_got) begin
                    if (w_cnt >= w_delay) begin
                        mem_wready = 1; w_hs++; last_wdata = mem_wdata; last_wstrb = mem_wstrb;
                        w_got = 1; w_cnt = 0;
                    end else w_cnt++;
                end
                if (aw_got && w_got && !b_pend) begin b_pend = 1; b_cnt = 0; end
            end
        end
    end

    function automatic wb_t mk(input logic gw, input logic [4:0] wa, input logic [31:0] wd,
                               input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                               input logic [4:0] frd, input logic err, input logic [3:0] tp,
                               input logic [31:0] pc);
        wb_t w;
        w.gw = gw;   w.wa = gw ? wa : '0;  w.wd = gw ? wd : '0;
        w.cw = cw;   w.ca = cw ? ca : '0;  w.cd = cw ? cd : '0;
        w.frd = frd; w.err = err; w.tp = err ? tp : '0; w.pc = err ? pc : '0;
        return w;
    endfunction

    function automatic req_t mkreq(input logic men, input logic write, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [1:0] mask, input logic rsign,
                                   input logic [4:0] ard, input logic [31:0] rd, input logic gen,
                                   input logic [11:0] acsr, input logic [31:0] csr, input logic sen,
                                   input logic [31:0] pc);
        req_t r;
        r.men = men; r.write = write; r.addr = addr; r.wdata = wdata; r.mask = mask;
        r.rsign = rsign; r.ard = ard; r.rd = rd; r.gen = gen; r.acsr = acsr; r.csr = csr;
        r.sen = sen; r.pc = pc;
        return r;
    endfunction

    task automatic set_req(input req_t r);
        abt_men = r.men; abt_write = r.write; abt_addr = r.addr; abt_wdata = r.wdata;
        abt_mask = r.mask; abt_rsign = r.rsign; abt_ard = r.ard; abt_rd = r.rd; abt_gen = r.gen;
        abt_acsr = r.acsr; abt_csr = r.csr; abt_sen = r.sen; abt_pc = r.pc;
    endtask

    // Drive a request until accepted; the expected WB record is queued at acceptance.
    task automatic send(input req_t r, input wb_t e, output int n);
        set_req(r);
        abt_valid = 1'b1;
        n = 0;
        while (!abt_ready && n < 100) begin @(negedge clock); n++; end
        if (abt_ready) exp_q.push_back(e);
        @(negedge clock);
        abt_valid = 1'b0;
    endtask

    task automatic wait_wb(output wb_t got, output wb_t e, output int n);
        n = 0;
        while (!abt_finish && n < 200) begin @(negedge clock); n++; end
        if (!abt_finish) n = -1;
        got = mk(gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata,
                 abt_frd, err_o, errtp_o, err_pc);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        compared++;
        if (abt_ready !== 1'b0) begin
            mismatched++; $display("FAIL reset_ready_low: got %b required 0", abt_ready);
        end
        compared++;
        if ({mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready, gpr_wen, csr_wen,
             abt_finish, err_o, gpr_wdata, mem_araddr, mem_wstrb} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got arv=%b rr=%b awv=%b wv=%b br=%b gw=%b cw=%b fin=%b err=%b wd=%h ara=%h strb=%b required all 0",
                     mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready, gpr_wen, csr_wen,
                     abt_finish, err_o, gpr_wdata, mem_araddr, mem_wstrb);
        end
        reset = 1'b0;
        @(negedge clock);
        compared++;
        if (abt_ready !== 1'b1) begin
            mismatched++; $display("FAIL reset_release_ready: got %b required 1", abt_ready);
        end
    endtask

    task automatic test_nonmem;
        wb_t got, e;
        int  n, busy0;
        busy0 = arv_cyc + awv_cyc + wv_cyc;
        send(mkreq(0, 0, 32'h0000_0040, '0, 2'b11, 0, 5'd5, 32'h1234, 1, 12'h305, 32'hDEAD_BEEF, 1, 32'h8000_0100),
             mk(1, 5'd5, 32'h1234, 1, 12'h305, 32'hDEAD_BEEF, 5'd5, 0, 4'd0, '0), n);
        wait_wb(got, e, n);
        compared++;
        if (got !== e || n !== 0) begin
            mismatched++; $display("FAIL nonmem_wb: got %h (wait %0d) required %h (wait 0)", got, n, e);
        end
        @(negedge clock);
        compared++;
        if (abt_ready !== 1'b1 || abt_finish !== 1'b0) begin
            mismatched++; $display("FAIL nonmem_ready_after: got ready=%b finish=%b required ready=1 finish=0", abt_ready, abt_finish);
        end
        compared++;
        if (arv_cyc + awv_cyc + wv_cyc !== busy0) begin
            mismatched++; $display("FAIL nonmem_no_bus: got %0d valid cycles required %0d", arv_cyc + awv_cyc + wv_cyc, busy0);
        end
    endtask

    task automatic test_load;
        logic [31:0] la [6] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0001, 32'h8000_0003, 32'h8000_0000, 32'h8000_0004};
        logic [1:0]  lm [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11};
        logic        ls [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] lw [6] = '{32'h8001_7F00, 32'h8001_7F00, 32'h1234_80FF, 32'h1234_80FF, 32'hCAFE_F00D, 32'hCAFE_F00D};
        logic [4:0]  ld [6] = '{5'd7, 5'd7, 5'd10, 5'd11, 5'd0, 5'd9};
        logic [31:0] lx [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80, 32'h0000_0012, 32'hCAFE_F00D, 32'hCAFE_F00D};
        logic [31:0] aa [6] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
        wb_t got, e;
        int  n;
        ar_delay = 0; r_delay = 0; rresp_cfg = 2'b00;
        for (int i = 0; i < 6; i++) begin
            mem_word = lw[i];
            send(mkreq(1, 0, la[i], '0, lm[i], ls[i], ld[i], la[i], 1, '0, '0, 0, 32'h8000_0200 + i),
                 mk(ld[i] != 0, ld[i], lx[i], 0, '0, '0, ld[i], 0, '0, '0), n);
            wait_wb(got, e, n);
            compared++;
            if (got !== e || n !== 2) begin
                mismatched++; $display("FAIL load_wb[%0d]: got %h (wait %0d) required %h (wait 2)", i, got, n, e);
            end
            compared++;
            if (last_araddr !== aa[i]) begin
                mismatched++; $display("FAIL load_araddr[%0d]: got %h required %h", i, last_araddr, aa[i]);
            end
        end
    endtask

    task automatic test_store;
        logic [31:0] sa [3] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0006};
        logic [1:0]  sm [3] = '{2'b01, 2'b01, 2'b10};
        logic [31:0] sd [3] = '{32'h0000_00AB, 32'h0000_00AB, 32'h1234_BEEF};
        int          ad [3] = '{0, 3, 0};
        int          wdl[3] = '{3, 0, 0};
        logic [1:0]  br [3] = '{2'b00, 2'b00, 2'b11};
        logic [31:0] xa [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
        logic [31:0] xd [3] = '{32'hAB00_0000, 32'hAB00_0000, 32'hBEEF_0000};
        logic [3:0]  xs [3] = '{4'b1000, 4'b1000, 4'b1100};
        int          xav[3] = '{1, 4, 1};
        int          xwv[3] = '{4, 1, 1};
        wb_t got, e;
        int  n, aw0, w0, awv0, wv0, st0;
        for (int i = 0; i < 3; i++) begin
            aw_delay = ad[i]; w_delay = wdl[i]; b_delay = 0; bresp_cfg = br[i];
            aw0 = aw_hs; w0 = w_hs; awv0 = awv_cyc; wv0 = wv_cyc; st0 = stray;
            send(mkreq(1, 1, sa[i], sd[i], sm[i], 0, 5'd3, sa[i], 0, '0, '0, 0, 32'h8000_0300 + i),
                 mk(0, '0, '0, 0, '0, '0, 5'd3, br[i] != 0, 4'd7, 32'h8000_0300 + i), n);
            wait_wb(got, e, n);
            compared++;
            if (got !== e || n < 0) begin
                mismatched++; $display("FAIL store_wb[%0d]: got %h (wait %0d) required %h", i, got, n, e);
            end
            compared++;
            if ({last_awaddr, last_wdata, last_wstrb} !== {xa[i], xd[i], xs[i]}) begin
                mismatched++; $display("FAIL store_beat[%0d]: got addr=%h data=%h strb=%b required addr=%h data=%h strb=%b",
                                       i, last_awaddr, last_wdata, last_wstrb, xa[i], xd[i], xs[i]);
            end
            compared++;
            if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || stray !== st0) begin
                mismatched++; $display("FAIL store_one_write[%0d]: got aw=%0d w=%0d stray=%0d required 1 1 0",
                                       i, aw_hs - aw0, w_hs - w0, stray - st0);
            end
            compared++;
            if (awv_cyc - awv0 !== xav[i] || wv_cyc - wv0 !== xwv[i]) begin
                mismatched++; $display("FAIL store_valid_len[%0d]: got awvalid=%0d wvalid=%0d required %0d %0d",
                                       i, awv_cyc - awv0, wv_cyc - wv0, xav[i], xwv[i]);
            end
        end
    endtask

    task automatic test_misaligned;
        wb_t got, e;
        int  n, busy0;
        busy0 = arv_cyc + awv_cyc + wv_cyc;
        send(mkreq(1, 0, 32'h8000_0006, '0, 2'b11, 0, 5'd4, 32'h8000_0006, 1, 12'h300, 32'h11, 1, 32'h8000_0040),
             mk(0, '0, '0, 1, 12'h300, 32'h11, 5'd4, 1, 4'd4, 32'h8000_0040), n);
        wait_wb(got, e, n);
        compared++;
        if (got !== e || n !== 0) begin
            mismatched++; $display("FAIL misal_load: got %h (wait %0d) required %h (wait 0)", got, n, e);
        end
        send(mkreq(1, 1, 32'h8000_0001, 32'h5555, 2'b10, 0, 5'd2, 32'h8000_0001, 0, '0, '0, 0, 32'h8000_0044),
             mk(0, '0, '0, 0, '0, '0, 5'd2, 1, 4'd6, 32'h8000_0044), n);
        wait_wb(got, e, n);
        compared++;
        if (got !== e || n !== 0) begin
            mismatched++; $display("FAIL misal_store: got %h (wait %0d) required %h (wait 0)", got, n, e);
        end
        compared++;
        if (arv_cyc + awv_cyc + wv_cyc !== busy0) begin
            mismatched++; $display("FAIL misal_no_bus: got %0d valid cycles required %0d", arv_cyc + awv_cyc + wv_cyc, busy0);
        end
    endtask

    task automatic test_back_to_back;
        req_t r1, r2;
        wb_t  e1, e2, got, e;
        int   n, acc0;
        ar_delay = 0; r_delay = 5; rresp_cfg = 2'b10; mem_word = 32'h0F0F_0F0F;
        r1 = mkreq(1, 0, 32'h8000_0010, '0, 2'b11, 0, 5'd6, 32'h8000_0010, 1, '0, '0, 0, 32'h8000_0500);
        r2 = mkreq(1, 0, 32'h8000_0011, '0, 2'b01, 1, 5'd8, 32'h8000_0011, 1, '0, '0, 0, 32'h8000_0504);
        e1 = mk(0, '0, '0, 0, '0, '0, 5'd6, 1, 4'd5, 32'h8000_0500);
        e2 = mk(0, '0, '0, 0, '0, '0, 5'd8, 1, 4'd5, 32'h8000_0504);
        acc0 = acc_cnt;
        send(r1, e1, n);
        set_req(r2);
        abt_valid = 1'b1;
        wait_wb(got, e, n);
        compared++;
        if (got !== e || n !== 7 || acc_cnt - acc0 !== 1) begin
            mismatched++; $display("FAIL b2b_first: got %h (wait %0d, accepts %0d) required %h (wait 7, accepts 1)",
                                   got, n, acc_cnt - acc0, e);
        end
        send(r2, e2, n);
        compared++;
        if (n !== 1 || acc_cnt - acc0 !== 2) begin
            mismatched++; $display("FAIL b2b_accept_once: got wait=%0d accepts=%0d required wait=1 accepts=2", n, acc_cnt - acc0);
        end
        wait_wb(got, e, n);
        compared++;
        if (got !== e || n !== 7) begin
            mismatched++; $display("FAIL b2b_second: got %h (wait %0d) required %h (wait 7)", got, n, e);
        end
        r_delay = 0; rresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid;
        wb_t got, e;
        int  n;
        r_delay = 50;
        send(mkreq(1, 0, 32'h8000_0020, '0, 2'b11, 0, 5'd12, '0, 1, '0, '0, 0, 32'h8000_0600),
             mk(1, 5'd12, '0, 0, '0, '0, 5'd12, 0, '0, '0), n);
        n = 0;
        while (!mem_rready && n < 10) begin @(negedge clock); n++; end
        compared++;
        if (mem_rready !== 1'b1) begin
            mismatched++; $display("FAIL resetmid_in_rdata: got rready=%b required 1", mem_rready);
        end
        reset = 1'b1;
        @(negedge clock);
        compared++;
        if ({mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready, gpr_wen, csr_wen,
             abt_finish, err_o, abt_ready} !== '0) begin
            mismatched++;
            $display("FAIL resetmid_cleared: got arv=%b rr=%b awv=%b wv=%b br=%b gw=%b cw=%b fin=%b err=%b rdy=%b required all 0",
                     mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready, gpr_wen, csr_wen,
                     abt_finish, err_o, abt_ready);
        end
        reset = 1'b0;
        exp_q.delete();
        r_delay = 0;
        @(negedge clock);
        compared++;
        if (abt_ready !== 1'b1 || abt_finish !== 1'b0) begin
            mismatched++; $display("FAIL resetmid_ready: got ready=%b finish=%b required 1 0", abt_ready, abt_finish);
        end
        send(mkreq(0, 0, '0, '0, 2'b00, 0, 5'd13, 32'h7777, 1, '0, '0, 0, 32'h8000_0604),
             mk(1, 5'd13, 32'h7777, 0, '0, '0, 5'd13, 0, '0, '0), n);
        wait_wb(got, e, n);
        compared++;
        if (got !== e || n !== 0) begin
            mismatched++; $display("FAIL resetmid_recover: got %h (wait %0d) required %h (wait 0)", got, n, e);
        end
    endtask

    initial begin
        test_reset;
        test_nonmem;
        test_load;
        test_store;
        test_misaligned;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required completion");
        $fatal(1);
    end

endmodule
